router_ctrl: RTL and testbench

- Control block for the 1x3 router: sequences packet loading into the three 16x9 output FIFOs and steers writes to the addressed FIFO.
- Drives per-port valid and soft-reset signals. Soft reset fires after 30 cycles of unread data at a port.
- Sits between the input register block, which holds header, payload and parity bytes, and the three FIFOs. Contains the packet FSM plus the address-latch/synchroniser logic.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_if.sv | 39 +++
 rtl/router_soft_reset_timer.sv | 35 +++
 rtl/router_ctrl.sv | 101 ++++++++++
 tb/tb_router_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control slice.
package router_pkg;

    localparam int         NUM_PORTS    = 3;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_t;

    // Address 3 has no FIFO behind it, so it maps to an all-zero enable.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
        logic [NUM_PORTS-1:0] sel;
        sel = '0;
        if (addr != ADDR_INVALID) begin
            sel[addr] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/router_if.sv
// Signal bundle between the packet source / register block / FIFOs and the router control.
interface router_if;
    import router_pkg::*;

    logic                 pkt_valid;
    logic [1:0]           data_in;
    logic                 parity_done;
    logic                 low_pkt_valid;
    logic [NUM_PORTS-1:0] fifo_full_in;
    logic [NUM_PORTS-1:0] fifo_empty_in;
    logic [NUM_PORTS-1:0] read_enb;

    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 busy;
    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;

    modport master (
        output pkt_valid, data_in, parity_done, low_pkt_valid,
               fifo_full_in, fifo_empty_in, read_enb,
        input  write_enb, fifo_full, vld_out, soft_reset, busy,
               detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
    );

    modport slave (
        input  pkt_valid, data_in, parity_done, low_pkt_valid,
               fifo_full_in, fifo_empty_in, read_enb,
        output write_enb, fifo_full, vld_out, soft_reset, busy,
               detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
    );

endinterface

// File: rtl/router_soft_reset_timer.sv
// Per-port idle-data watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_soft_reset_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt_reg;
    logic             soft_reset_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg        <= '0;
            soft_reset_reg <= 1'b0;
        end else if (!vld || read_enb) begin
            cnt_reg        <= '0;
            soft_reset_reg <= 1'b0;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            cnt_reg        <= '0;
            soft_reset_reg <= 1'b1;
        end else begin
            cnt_reg        <= cnt_reg + CNT_W'(1);
            soft_reset_reg <= 1'b0;
        end
    end

    assign soft_reset = soft_reset_reg;

endmodule

// File: rtl/router_ctrl.sv
// 1x3 router control: packet-loading FSM, destination address latch,
// FIFO write steering and per-port idle timeout.
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic     clk,
    input  logic     reset,
    router_if.slave  bus
);

    router_state_t        state_reg;
    logic [1:0]           addr_reg;
    logic [NUM_PORTS-1:0] vld;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_hit;
    logic                 fifo_full_sel;
    logic                 load_phase;

    assign addr_hit      = bus.pkt_valid && (bus.data_in != ADDR_INVALID);
    assign vld           = ~bus.fifo_empty_in;
    assign fifo_full_sel = bus.fifo_full_in[addr_reg];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_timer
            router_soft_reset_timer #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (CNT_W)
            ) u_timer (
                .clk        (clk),
                .reset      (reset),
                .vld        (vld[gi]),
                .read_enb   (bus.read_enb[gi]),
                .soft_reset (soft_reset[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= DECODE_ADDRESS;
            addr_reg  <= '0;
        end else begin
            if (state_reg == DECODE_ADDRESS && addr_hit) begin
                addr_reg <= bus.data_in;
            end
            // A timed-out destination aborts whatever packet is in flight.
            if (state_reg != DECODE_ADDRESS && soft_reset[addr_reg]) begin
                state_reg <= DECODE_ADDRESS;
            end else begin
                case (state_reg)
                    DECODE_ADDRESS: begin
                        if (addr_hit) begin
                            state_reg <= bus.fifo_empty_in[bus.data_in] ? LOAD_FIRST_DATA
                                                                        : WAIT_TILL_EMPTY;
                        end
                    end
                    LOAD_FIRST_DATA: state_reg <= LOAD_DATA;
                    LOAD_DATA: begin
                        if (fifo_full_sel)       state_reg <= FIFO_FULL_STATE;
                        else if (!bus.pkt_valid) state_reg <= LOAD_PARITY;
                    end
                    FIFO_FULL_STATE: begin
                        if (!fifo_full_sel) state_reg <= LOAD_AFTER_FULL;
                    end
                    LOAD_AFTER_FULL: begin
                        if (bus.parity_done)        state_reg <= DECODE_ADDRESS;
                        else if (bus.low_pkt_valid) state_reg <= LOAD_PARITY;
                        else                        state_reg <= LOAD_DATA;
                    end
                    LOAD_PARITY: state_reg <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        state_reg <= fifo_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    end
                    WAIT_TILL_EMPTY: begin
                        if (bus.fifo_empty_in[addr_reg]) state_reg <= LOAD_FIRST_DATA;
                    end
                    default: state_reg <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign load_phase = (state_reg == LOAD_FIRST_DATA) || (state_reg == LOAD_DATA) ||
                        (state_reg == LOAD_PARITY)     || (state_reg == LOAD_AFTER_FULL);

    assign bus.write_enb   = load_phase ? port_onehot(addr_reg) : '0;
    assign bus.fifo_full   = fifo_full_sel;
    assign bus.vld_out     = vld;
    assign bus.soft_reset  = soft_reset;
    assign bus.busy        = !((state_reg == DECODE_ADDRESS) || (state_reg == LOAD_DATA));
    assign bus.detect_add  = (state_reg == DECODE_ADDRESS);
    assign bus.lfd_state   = (state_reg == LOAD_FIRST_DATA);
    assign bus.ld_state    = (state_reg == LOAD_DATA);
    assign bus.laf_state   = (state_reg == LOAD_AFTER_FULL);
    assign bus.full_state  = (state_reg == FIFO_FULL_STATE);
    assign bus.rst_int_reg = (state_reg == CHECK_PARITY_ERROR);

endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the router rules.
module tb_router_ctrl;

    localparam int TIMEOUT = 30;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    router_if bus();

    router_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: phase by name, latched destination, unread-run length and pulse per port.
    string    m_st;
    int       m_addr;
    int       m_run [3];
    bit [2:0] m_sr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = "DECODE";
        m_addr = 0;
        m_sr   = 3'b000;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    task automatic model_update();
        string nx;
        bit    full_m;
        full_m = bus.fifo_full_in[m_addr];
        nx     = m_st;
        if (m_st != "DECODE" && m_sr[m_addr]) nx = "DECODE";
        else if (m_st == "DECODE") begin
            if (bus.pkt_valid && bus.data_in != 2'd3)
                nx = bus.fifo_empty_in[bus.data_in] ? "LFD" : "WAIT";
        end
        else if (m_st == "LFD")  nx = "LD";
        else if (m_st == "LD")   nx = full_m ? "FULL" : (!bus.pkt_valid ? "LP" : "LD");
        else if (m_st == "FULL") nx = full_m ? "FULL" : "LAF";
        else if (m_st == "LAF")  nx = bus.parity_done ? "DECODE" : (bus.low_pkt_valid ? "LP" : "LD");
        else if (m_st == "LP")   nx = "CPE";
        else if (m_st == "CPE")  nx = full_m ? "FULL" : "DECODE";
        else if (m_st == "WAIT") nx = bus.fifo_empty_in[m_addr] ? "LFD" : "WAIT";

        if (m_st == "DECODE" && bus.pkt_valid && bus.data_in != 2'd3) m_addr = int'(bus.data_in);

        for (int i = 0; i < 3; i++) begin
            if (bus.fifo_empty_in[i] || bus.read_enb[i]) begin
                m_run[i] = 0;
                m_sr[i]  = 1'b0;
            end else begin
                m_run[i] = m_run[i] + 1;
                m_sr[i]  = (m_run[i] == TIMEOUT);
                if (m_sr[i]) m_run[i] = 0;
            end
        end
        m_st = nx;
    endtask

    task automatic compare_all();
        bit [2:0] we_exp;
        bit [2:0] vld_exp;
        bit       loading;
        loading = (m_st == "LFD") || (m_st == "LD") || (m_st == "LP") || (m_st == "LAF");
        we_exp  = loading ? 3'(1 << m_addr) : 3'b000;
        vld_exp = ~bus.fifo_empty_in;
        check("detect_add",  bus.detect_add,  m_st == "DECODE");
        check("lfd_state",   bus.lfd_state,   m_st == "LFD");
        check("ld_state",    bus.ld_state,    m_st == "LD");
        check("laf_state",   bus.laf_state,   m_st == "LAF");
        check("full_state",  bus.full_state,  m_st == "FULL");
        check("rst_int_reg", bus.rst_int_reg, m_st == "CPE");
        check("busy",        bus.busy,        !(m_st == "DECODE" || m_st == "LD"));
        check("write_enb",   bus.write_enb,   we_exp);
        check("fifo_full",   bus.fifo_full,   bus.fifo_full_in[m_addr]);
        check("vld_out",     bus.vld_out,     vld_exp);
        check("soft_reset",  bus.soft_reset,  m_sr);
    endtask

    task automatic set_in(input bit pv, input bit [1:0] di, input bit [2:0] emp,
                          input bit [2:0] full, input bit [2:0] rd, input bit pd, input bit lpv);
        bus.pkt_valid     = pv;
        bus.data_in       = di;
        bus.fifo_empty_in = emp;
        bus.fifo_full_in  = full;
        bus.read_enb      = rd;
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;
    endtask

    // Entered at posedge+1; compares mid-cycle, then advances the model at the edge.
    task automatic step();
        #4;
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic async_reset_pulse(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_detect_add"}, bus.detect_add, 1'b1);
        check({tag, "_write_enb"},  bus.write_enb,  3'b000);
        check({tag, "_soft_reset"}, bus.soft_reset, 3'b000);
        check({tag, "_busy"},       bus.busy,       1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    bit       pv_r;
    bit [2:0] emp_r;
    bit [2:0] full_r;
    bit [2:0] rd_r;

    initial begin
        set_in(0, 2'd0, 3'b111, 3'b000, 3'b000, 0, 0);
        model_reset();
        #2;
        check("rst_detect_add", bus.detect_add, 1'b1);
        check("rst_busy",       bus.busy,       1'b0);
        check("rst_write_enb",  bus.write_enb,  3'b000);
        check("rst_soft_reset", bus.soft_reset, 3'b000);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Header to port 1, short packet through parity check.
        set_in(1, 2'd1, 3'b111, 3'b000, 3'b000, 0, 0);
        step();
        check("hdr1_lfd",  bus.lfd_state, 1'b1);
        check("hdr1_we",   bus.write_enb, 3'b010);
        check("hdr1_busy", bus.busy,      1'b1);
        step();
        check("hdr1_ld",   bus.ld_state,  1'b1);
        check("hdr1_busy_ld", bus.busy,   1'b0);
        bus.pkt_valid = 0;
        step();
        step();
        check("hdr1_cpe",  bus.rst_int_reg, 1'b1);
        step();
        check("hdr1_done", bus.detect_add, 1'b1);

        // Port 2 hits a full FIFO, resumes, then low_pkt_valid goes to parity.
        set_in(1, 2'd2, 3'b111, 3'b000, 3'b000, 0, 0);
        step();
        step();
        bus.fifo_full_in = 3'b100;
        step();
        check("full_state", bus.full_state, 1'b1);
        check("full_we",    bus.write_enb,  3'b000);
        check("full_busy",  bus.busy,       1'b1);
        bus.fifo_full_in = 3'b000;
        step();
        check("laf_state",  bus.laf_state,  1'b1);
        check("laf_we",     bus.write_enb,  3'b100);
        bus.low_pkt_valid = 1;
        step();
        check("laf_to_lp_we",   bus.write_enb, 3'b100);
        check("laf_to_lp_busy", bus.busy,      1'b1);
        set_in(0, 2'd0, 3'b111, 3'b000, 3'b000, 0, 0);
        step();
        step();

        // Port 0 not empty: wait, then load once it drains.
        set_in(1, 2'd0, 3'b110, 3'b000, 3'b001, 0, 0);
        step();
        bus.pkt_valid = 0;
        for (int k = 0; k < 3; k++) begin
            check("wait_busy", bus.busy,      1'b1);
            check("wait_we",   bus.write_enb, 3'b000);
            step();
        end
        bus.fifo_empty_in = 3'b111;
        step();
        check("wait_to_lfd", bus.lfd_state, 1'b1);
        step();
        step();
        step();
        step();

        // Port 1 left unread: pulse on the 30th cycle, aborts the pending packet.
        set_in(0, 2'd0, 3'b111, 3'b000, 3'b000, 0, 0);
        step();
        set_in(1, 2'd1, 3'b101, 3'b000, 3'b000, 0, 0);
        step();
        bus.pkt_valid = 0;
        for (int k = 2; k <= 31; k++) begin
            step();
            if (k == 29) check("to_sr_c29", bus.soft_reset, 3'b000);
            if (k == 30) begin
                check("to_sr_c30",  bus.soft_reset, 3'b010);
                check("to_busy_30", bus.detect_add, 1'b0);
            end
            if (k == 31) begin
                check("to_sr_c31",  bus.soft_reset, 3'b000);
                check("to_abort",   bus.detect_add, 1'b1);
            end
        end

        // A read in the would-be pulse cycle suppresses it.
        set_in(0, 2'd0, 3'b111, 3'b000, 3'b000, 0, 0);
        step();
        bus.fifo_empty_in = 3'b101;
        repeat (29) step();
        bus.read_enb = 3'b010;
        step();
        check("sup_sr_a", bus.soft_reset, 3'b000);
        bus.read_enb = 3'b000;
        step();
        check("sup_sr_b", bus.soft_reset, 3'b000);

        // Invalid address 3: stay in decode, latch keeps port 1.
        set_in(1, 2'd3, 3'b111, 3'b010, 3'b000, 0, 0);
        step();
        check("inv_detect", bus.detect_add, 1'b1);
        check("inv_we",     bus.write_enb,  3'b000);
        check("inv_addr",   bus.fifo_full,  1'b1);
        bus.fifo_full_in = 3'b101;
        step();
        check("inv_addr_b", bus.fifo_full,  1'b0);

        // Asynchronous reset in the middle of LOAD_DATA.
        set_in(1, 2'd0, 3'b111, 3'b000, 3'b000, 0, 0);
        step();
        step();
        check("pre_rst_ld", bus.ld_state, 1'b1);
        async_reset_pulse("arst");

        // Random traffic with sticky flags so timeouts and stalls occur.
        pv_r   = 0;
        emp_r  = 3'b111;
        full_r = 3'b000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(7) == 0) pv_r = ~pv_r;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(15) == 0) emp_r[i]  = ~emp_r[i];
                if ($urandom_range(7) == 0)  full_r[i] = ~full_r[i];
                rd_r[i] = ($urandom_range(47) == 0);
            end
            set_in(pv_r, 2'($urandom_range(3)), emp_r, full_r, rd_r,
                   $urandom_range(3) == 0, $urandom_range(3) == 0);
            if (n == 750) async_reset_pulse("rnd_arst");
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
